// File: rtl/note_selector_pkg.sv
// Shared types, widths and helpers for the note selector slice.
package note_selector_pkg;

  localparam int SCORE_W = 32;
  localparam int SQ_W    = 64;
  localparam int CROSS_W = 96;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_THRESH  = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/note_selector_if.sv
// Correlator-bank inputs and per-frame note decision outputs of the note selector.
interface note_selector_if #(
  parameter int NUM_REFS = 8,
  parameter int DOT_W    = 42,
  parameter int NORM_W   = 32
);
  import note_selector_pkg::*;

  localparam int IDX_W = idx_w(NUM_REFS);

  logic [NUM_REFS*DOT_W-1:0]  dot_bus;
  logic [NUM_REFS*NORM_W-1:0] norm_bus;
  logic [NUM_REFS-1:0]        dot_valid;
  logic                       frame_valid;
  logic [IDX_W-1:0]           frame_note;
  logic                       frame_hit;
  logic [IDX_W-1:0]           note_id;
  logic                       note_present;
  logic                       frame_dropped;

  modport master (
    output dot_bus, norm_bus, dot_valid,
    input  frame_valid, frame_note, frame_hit, note_id, note_present, frame_dropped
  );

  modport slave (
    input  dot_bus, norm_bus, dot_valid,
    output frame_valid, frame_note, frame_hit, note_id, note_present, frame_dropped
  );

endinterface

// File: rtl/score_cross_mult.sv
// Two-stage squaring + cross multiplier: stage 1 squares d_in, stage 2 forms
// L = sq*norm_b and R = sq_b*norm_i. Free-running, no flow control.
module score_cross_mult
  import note_selector_pkg::*;
#(
  parameter int NORM_W = 32
) (
  input  logic                clk,
  input  logic [SCORE_W-1:0]  d_in,
  input  logic                sq_ovr_en,
  input  logic [SQ_W-1:0]     sq_ovr,
  input  logic [NORM_W-1:0]   norm_b,
  input  logic [NORM_W-1:0]   norm_i,
  input  logic [SQ_W-1:0]     sq_b,
  output logic [SQ_W-1:0]     sq_q,
  output logic [CROSS_W-1:0]  l_q,
  output logic [CROSS_W-1:0]  r_q
);

  logic [SQ_W-1:0] sq_sel;

  // The threshold test reuses stage 2 by substituting the threshold for the square.
  assign sq_sel = sq_ovr_en ? sq_ovr : sq_q;

  always_ff @(posedge clk) begin
    sq_q <= SQ_W'(d_in) * SQ_W'(d_in);
    l_q  <= CROSS_W'(sq_sel) * CROSS_W'(norm_b);
    r_q  <= CROSS_W'(sq_b) * CROSS_W'(norm_i);
  end

endmodule

// File: rtl/note_selector.sv
// Picks the reference note with the highest dot^2/norm score each frame, 4*NUM_REFS+5 cycles after the last capture.
// NOTE_SELECTOR_DEBOUNCE_EN: note_id/note_present move only after DEBOUNCE_FRAMES identical frames.
module note_selector
  import note_selector_pkg::*;
#(
  parameter int          NUM_REFS        = 8,
  parameter int          DOT_W           = 42,
  parameter int          NORM_W          = 32,
  parameter logic [31:0] THRESH          = 32'd0,
  parameter int          DEBOUNCE_FRAMES = 3
) (
  input logic            clk,
  input logic            rst_n,
  note_selector_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REFS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REFS - 1);

  state_t               state, state_nxt;
  logic [NUM_REFS-1:0]  got, got_all;
  logic [SCORE_W-1:0]   dot_cap  [NUM_REFS];
  logic [NORM_W-1:0]    norm_cap [NUM_REFS];
  logic [IDX_W-1:0]     idx, best_idx, note_c;
  logic [1:0]           phase;
  logic [SCORE_W-1:0]   cand_d;
  logic [NORM_W-1:0]    cand_n, norm_op, norm_b;
  logic [SQ_W-1:0]      sq_q, sq_b;
  logic [CROSS_W-1:0]   l_q, r_q;
  logic                 best_valid, thr_sel, hit_c;
  logic                 unused_dot_lsbs;

  assign got_all = got | bus.dot_valid;
  assign thr_sel = (state == ST_THRESH);
  assign norm_op = thr_sel ? NORM_W'(1) : cand_n;
  assign note_c  = best_valid ? best_idx : '0;
  // In EMIT the multiplier holds L = THRESH*norm_b and R = sq_b*1.
  assign hit_c   = best_valid && (r_q >= l_q);
  // Scores use only the top SCORE_W bits of each dot product.
  assign unused_dot_lsbs = ^bus.dot_bus;

  score_cross_mult #(.NORM_W(NORM_W)) u_mult (
    .clk       (clk),
    .d_in      (cand_d),
    .sq_ovr_en (thr_sel),
    .sq_ovr    (SQ_W'(THRESH)),
    .norm_b    (norm_b),
    .norm_i    (norm_op),
    .sq_b      (sq_b),
    .sq_q      (sq_q),
    .l_q       (l_q),
    .r_q       (r_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (&got_all) state_nxt = ST_SCAN;
      ST_SCAN:    if (phase == 2'd3 && idx == LAST_IDX) state_nxt = ST_THRESH;
      ST_THRESH:  if (phase == 2'd3) state_nxt = ST_EMIT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ST_COLLECT) begin
      for (int i = 0; i < NUM_REFS; i++) begin
        if (bus.dot_valid[i]) begin
          dot_cap[i]  <= bus.dot_bus[i*DOT_W + DOT_W - 1 -: SCORE_W];
          norm_cap[i] <= bus.norm_bus[i*NORM_W +: NORM_W];
        end
      end
    end
    if (state == ST_SCAN && phase == 2'd0) begin
      cand_d <= dot_cap[idx];
      cand_n <= norm_cap[idx];
    end
  end

`ifdef NOTE_SELECTOR_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_FRAMES);

  logic [DB_W-1:0] db_cnt, db_nxt;
  logic [IDX_W:0]  db_key;

  always_comb begin
    db_nxt = DB_W'(1);
    if (db_cnt != '0 && db_key == {hit_c, note_c})
      db_nxt = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      got               <= '0;
      idx               <= '0;
      phase             <= '0;
      best_valid        <= 1'b0;
      best_idx          <= '0;
      sq_b              <= '0;
      norm_b            <= '0;
      bus.frame_valid   <= 1'b0;
      bus.frame_note    <= '0;
      bus.frame_hit     <= 1'b0;
      bus.note_id       <= '0;
      bus.note_present  <= 1'b0;
      bus.frame_dropped <= 1'b0;
`ifdef NOTE_SELECTOR_DEBOUNCE_EN
      db_cnt            <= '0;
      db_key            <= '0;
`endif
    end else begin
      bus.frame_valid   <= 1'b0;
      bus.frame_dropped <= (state != ST_COLLECT) && (|bus.dot_valid);
      case (state)
        ST_COLLECT: begin
          got        <= (&got_all) ? '0 : got_all;
          idx        <= '0;
          phase      <= '0;
          best_valid <= 1'b0;
          best_idx   <= '0;
        end
        ST_SCAN: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            idx <= idx + IDX_W'(1);
            // Strict '>' keeps the lower index on ties; zero norm is never eligible.
            if (cand_n != '0 && (!best_valid || l_q > r_q)) begin
              best_valid <= 1'b1;
              best_idx   <= idx;
              sq_b       <= sq_q;
              norm_b     <= cand_n;
            end
          end
        end
        ST_THRESH: phase <= phase + 2'd1;
        default: begin
          bus.frame_valid <= 1'b1;
          bus.frame_note  <= note_c;
          bus.frame_hit   <= hit_c;
`ifdef NOTE_SELECTOR_DEBOUNCE_EN
          db_cnt <= db_nxt;
          db_key <= {hit_c, note_c};
          if (db_nxt == DB_MAX) begin
            bus.note_present <= hit_c;
            bus.note_id      <= note_c;
          end
`else
          bus.note_present <= hit_c;
          bus.note_id      <= note_c;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_selector.sv
// Directed bench for note_selector: frame-level model plus literal expectations.
module tb_note_selector;

  localparam int          NR     = 8;
  localparam int          DOT_W  = 42;
  localparam int          NORM_W = 32;
  localparam int          IW     = 3;
  localparam logic [31:0] THR    = 32'd0;
  localparam int          DBF    = 3;
  localparam int          LAT    = 4*NR + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_selector_if #(.NUM_REFS(NR), .DOT_W(DOT_W), .NORM_W(NORM_W)) sif ();

  note_selector #(
    .NUM_REFS(NR), .DOT_W(DOT_W), .NORM_W(NORM_W),
    .THRESH(THR), .DEBOUNCE_FRAMES(DBF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int errs = 0;
  int checks = 0;
  int edge_n = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct {
    int            due;
    logic [IW-1:0] note;
    logic          hit;
  } res_t;

  logic [31:0]   md [NR];
  logic [31:0]   mn [NR];
  logic [NR-1:0] mgot = '0;
  int            busy_end = -1;
  res_t          q[$];
  logic          exp_fv = 0, exp_hit = 0, exp_pres = 0, exp_drop = 0;
  logic [IW-1:0] exp_note = 0, exp_id = 0;
  int            db_cnt = 0;
  logic [IW:0]   db_key = 0;

  function automatic res_t decide(input int due);
    res_t r;
    int b = -1;
    logic [127:0] lhs, rhs;
    for (int i = 0; i < NR; i++) begin
      if (mn[i] != 0) begin
        if (b < 0) b = i;
        else begin
          lhs = 128'(md[i]) * 128'(md[i]) * 128'(mn[b]);
          rhs = 128'(md[b]) * 128'(md[b]) * 128'(mn[i]);
          if (lhs > rhs) b = i;
        end
      end
    end
    r.due  = due;
    r.note = (b < 0) ? '0 : IW'(b);
    r.hit  = (b >= 0) && (128'(md[b]) * 128'(md[b]) >= 128'(THR) * 128'(mn[b]));
    return r;
  endfunction

  always @(posedge clk) begin
    res_t r;
    edge_n++;
    if (!rst_n) begin
      mgot = '0; q.delete(); busy_end = -1;
      exp_fv = 0; exp_note = 0; exp_hit = 0; exp_id = 0; exp_pres = 0; exp_drop = 0;
      db_cnt = 0; db_key = 0;
    end else begin
      exp_fv = 0;
      exp_drop = 0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        r = q.pop_front();
        exp_fv = 1; exp_note = r.note; exp_hit = r.hit;
`ifdef NOTE_SELECTOR_DEBOUNCE_EN
        if (db_cnt != 0 && db_key == {r.hit, r.note}) begin
          if (db_cnt < DBF) db_cnt++;
        end else db_cnt = 1;
        db_key = {r.hit, r.note};
        if (db_cnt == DBF) begin exp_pres = r.hit; exp_id = r.note; end
`else
        exp_pres = r.hit; exp_id = r.note;
`endif
      end
      if (sif.dot_valid != 0) begin
        if (edge_n <= busy_end) exp_drop = 1;
        else begin
          for (int i = 0; i < NR; i++) begin
            if (sif.dot_valid[i]) begin
              md[i] = sif.dot_bus[i*DOT_W + DOT_W - 1 -: 32];
              mn[i] = sif.norm_bus[i*NORM_W +: NORM_W];
            end
          end
          mgot = mgot | sif.dot_valid;
          if (&mgot) begin
            q.push_back(decide(edge_n + LAT));
            busy_end = edge_n + LAT;
            mgot = '0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0)
      chk("cycle_outputs",
          {sif.frame_valid, sif.frame_note, sif.frame_hit, sif.note_id, sif.note_present, sif.frame_dropped},
          {exp_fv, exp_note, exp_hit, exp_id, exp_pres, exp_drop});
  end

  // ---------------- stimulus ----------------
  logic [31:0] fd [NR];
  logic [31:0] fn [NR];
  int wseq [6] = '{5, 5, 2, 5, 5, 5};

  task automatic fill(input logic [31:0] d, input logic [31:0] n);
    for (int i = 0; i < NR; i++) begin fd[i] = d; fn[i] = n; end
  endtask

  task automatic set_slot(input int i, input logic [31:0] d, input logic [31:0] n);
    sif.dot_bus[i*DOT_W +: DOT_W]    = {d, 10'h2A5};
    sif.norm_bus[i*NORM_W +: NORM_W] = n;
  endtask

  task automatic send_all(output int t0);
    for (int i = 0; i < NR; i++) set_slot(i, fd[i], fn[i]);
    sif.dot_valid = '1;
    @(negedge clk);
    sif.dot_valid = '0;
    t0 = edge_n;
  endtask

  task automatic wait_fv(input int t0, output int lat);
    int k = 0;
    lat = -1;
    while (lat < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (sif.frame_valid) lat = edge_n - t0;
    end
  endtask

  task automatic run_frame(input string nm, input int en, input int eh);
    int t0, lat;
    send_all(t0);
    wait_fv(t0, lat);
    chk({nm, "_latency"}, lat, LAT);
    chk({nm, "_note"}, sif.frame_note, en);
    chk({nm, "_hit"}, sif.frame_hit, eh);
`ifndef NOTE_SELECTOR_DEBOUNCE_EN
    chk({nm, "_present"}, sif.note_present, eh);
    chk({nm, "_id"}, sif.note_id, en);
`endif
  endtask

  initial begin
    int t0, lat, drops, nfv, k;
    sif.dot_bus = '0; sif.norm_bus = '0; sif.dot_valid = '0;
    repeat (3) @(negedge clk);
    chk("rst_frame_valid", sif.frame_valid, 0);
    chk("rst_note_present", sif.note_present, 0);
    chk("rst_frame_dropped", sif.frame_dropped, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ascending dots, equal norms: slot 7 wins.
    fill(0, 1000);
    for (int i = 0; i < NR; i++) fd[i] = 100 * i;
    run_frame("ascending", 7, 1);

    // Slots 2 and 5 tie on score 4: lower index wins.
    fill(10, 1000);
    fd[2] = 20; fn[2] = 100; fd[5] = 40; fn[5] = 400;
    run_frame("tie", 2, 1);

    // Staggered capture over 20 cycles, slot 3 overwritten with a larger dot.
    for (int s = 0; s < 20; s++) begin
      sif.dot_valid = '0;
      case (s)
        0:  begin set_slot(0, 100, 1000); sif.dot_valid = 8'h01; end
        2:  begin set_slot(3, 5, 1000);   sif.dot_valid = 8'h08; end
        4:  begin set_slot(1, 100, 1000); set_slot(2, 100, 1000); sif.dot_valid = 8'h06; end
        7:  begin set_slot(4, 100, 1000); sif.dot_valid = 8'h10; end
        9:  begin set_slot(5, 100, 1000); sif.dot_valid = 8'h20; end
        12: begin set_slot(6, 100, 1000); sif.dot_valid = 8'h40; end
        15: begin set_slot(3, 900, 1000); sif.dot_valid = 8'h08; end
        19: begin set_slot(7, 100, 1000); sif.dot_valid = 8'h80; end
        default: ;
      endcase
      @(negedge clk);
    end
    sif.dot_valid = '0;
    t0 = edge_n;
    wait_fv(t0, lat);
    chk("stagger_latency", lat, LAT);
    chk("stagger_note", sif.frame_note, 3);

    // No eligible candidate.
    fill(0, 0);
    for (int i = 0; i < NR; i++) fd[i] = 100 * i;
    run_frame("all_norm0", 0, 0);

    // Largest dot sits on a zero-norm slot.
    fill(0, 1000);
    for (int i = 0; i < NR; i++) fd[i] = 100 * i + 1;
    fd[4] = 5000; fn[4] = 0;
    run_frame("norm4_zero", 7, 1);

    // Zero score still meets a zero threshold.
    fill(0, 1000);
    run_frame("zero_dots", 0, 1);

    // Valids during SCAN and during EMIT are dropped; next frame right after EMIT.
    fill(10, 1000);
    fd[1] = 300;
    send_all(t0);
    drops = 0; lat = -1; k = 0;
    while (lat < 0 && k < 200) begin
      @(negedge clk);
      k++;
      sif.dot_valid = '0;
      drops += int'(sif.frame_dropped);
      if (sif.frame_valid) lat = edge_n - t0;
      else if (edge_n == t0 + 5) begin set_slot(7, 9999, 1000); sif.dot_valid = 8'h80; end
      else if (edge_n == t0 + 36) sif.dot_valid = 8'h01;
    end
    chk("drop_latency", lat, LAT);
    chk("drop_pulses", drops, 2);
    chk("drop_note", sif.frame_note, 1);
    fill(10, 1000);
    fd[4] = 300;
    run_frame("after_emit", 4, 1);

`ifdef NOTE_SELECTOR_DEBOUNCE_EN
    for (int f = 0; f < 6; f++) begin
      fill(10, 1000);
      fd[wseq[f]] = 500;
      send_all(t0);
      wait_fv(t0, lat);
      chk("deb_note", sif.frame_note, wseq[f]);
      chk("deb_present", sif.note_present, (f == 5) ? 1 : 0);
      if (f == 5) chk("deb_id", sif.note_id, 5);
    end
`endif

    // Reset in the middle of SCAN aborts the frame.
    fill(10, 1000);
    fd[6] = 300;
    send_all(t0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nfv = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      nfv += int'(sif.frame_valid);
    end
    chk("rstmid_fv_count", nfv, 0);
    chk("rstmid_present", sif.note_present, 0);
    chk("rstmid_note", sif.frame_note, 0);
    chk("rstmid_hit", sif.frame_hit, 0);
    fill(10, 1000);
    fd[2] = 300;
    send_all(t0);
    wait_fv(t0, lat);
    chk("recover_latency", lat, LAT);
    chk("recover_note", sif.frame_note, 2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
